// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB master.
// A valid/ready request is decoded against the peripheral window. An in-window
// request is issued on APB as a SETUP/ACCESS pair. An out-of-window request
// completes at once with an error. An ACCESS phase that waits too long is ended
// with an error response, so a dead slave cannot stall the requester.

// Protocol checker bound into the initiator; it observes ports only.
module apb_initiator_chk #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  req_ready_i,
  input logic                  rsp_valid_i,
  input logic                  rsp_ready_i,
  input logic                  rsp_err_i,
  input logic [DATA_WIDTH-1:0] rsp_rdata_i,
  input logic [ADDR_WIDTH-1:0] paddr_i,
  input logic [DATA_WIDTH-1:0] pwdata_i,
  input logic                  pwrite_i,
  input logic                  psel_i,
  input logic                  penable_i
);

  // penable is only ever raised inside a selected transfer.
  penable_implies_psel_a: assert property (
    @(posedge clk) disable iff (rst) penable_i |-> psel_i);

  // Address, data and direction do not move while ACCESS is in progress.
  access_stable_a: assert property (
    @(posedge clk) disable iff (rst)
    (psel_i && penable_i) |-> ($stable(paddr_i) && $stable(pwdata_i) && $stable(pwrite_i)));

  // A stalled response keeps its payload until it is taken.
  rsp_hold_a: assert property (
    @(posedge clk) disable iff (rst)
    (rsp_valid_i && !rsp_ready_i) |=> (rsp_valid_i && $stable(rsp_err_i) && $stable(rsp_rdata_i)));

  // Ready for a new request means the bus is idle and no response is pending.
  idle_clean_a: assert property (
    @(posedge clk) disable iff (rst) req_ready_i |-> (!rsp_valid_i && !psel_i));

endmodule

module apb_initiator #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_START  = 32'h1A10_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_END    = 32'h1A11_7FFF,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // request channel
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  // response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  // APB master
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  // The counter only has to reach TIMEOUT-1; one bit is enough when the
  // timeout is tiny or disabled.
  localparam int unsigned      CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1)
                                                       : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  pwrite_q,    pwrite_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]      to_cnt_q,    to_cnt_d;

  // Unsigned inclusive compare over the full address width; no alignment check.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= WIN_START) && (addr <= WIN_END);
  endfunction

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (in_window(req_addr_i)) begin
            state_d   = S_SETUP;
            paddr_d   = req_addr_i;
            pwdata_d  = req_wdata_i;
            pwrite_d  = req_we_i;
            psel_d    = 1'b1;
            penable_d = 1'b0;
          end else begin
            // Decode error: answer directly, the APB bus stays untouched.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        to_cnt_d  = {CNT_W{1'b0}};
      end

      S_ACCESS: begin
        if (pready_i) begin
          // A ready slave wins over a timeout landing on the same cycle.
          state_d     = S_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : {DATA_WIDTH{1'b0}};
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          state_d     = S_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          to_cnt_d = to_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d     = S_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      to_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

  apb_initiator_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .req_ready_i (req_ready_o),
    .rsp_valid_i (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_err_i   (rsp_err_o),
    .rsp_rdata_i (rsp_rdata_o),
    .paddr_i     (paddr_o),
    .pwdata_i    (pwdata_o),
    .pwrite_i    (pwrite_o),
    .psel_i      (psel_o),
    .penable_i   (penable_o)
  );

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator (TIMEOUT=4). Inputs change 1 ns after the
// rising edge and outputs are sampled there, so "cycle n" is the cycle that
// follows the n-th edge after the request is presented.
module tb_apb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_initiator #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .WIN_START  (32'h1A10_0000),
    .WIN_END    (32'h1A11_7FFF),
    .TIMEOUT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .pwrite_o    (pwrite),
    .psel_o      (psel),
    .penable_o   (penable),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One in-window transfer. The slave answers on ACCESS cycle 'waits'
  // (never, if waits >= n_access); n_access is the number of ACCESS cycles
  // the bench expects before the response appears.
  task automatic run_xfer(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input int waits, input int n_access,
                          input logic [31:0] rd, input logic serr,
                          input logic [31:0] exp_rdata, input logic exp_err);
    // cycle 0: request presented in IDLE
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata;
    check({tag, ".c0_ready"}, 64'(req_ready), 64'd1);
    check({tag, ".c0_psel"},  64'(psel),      64'd0);
    tick();
    // cycle 1: SETUP; scramble the request fields to prove they were latched
    req_valid = 1'b0; req_addr = ~addr; req_we = ~we; req_wdata = ~wdata;
    check({tag, ".setup_sel_en"}, 64'({psel, penable}), 64'b10);
    check({tag, ".setup_addr"},   64'(paddr),  64'(addr));
    check({tag, ".setup_wdata"},  64'(pwdata), 64'(wdata));
    check({tag, ".setup_write"},  64'(pwrite), 64'(we));
    check({tag, ".setup_ready"},  64'(req_ready), 64'd0);
    tick();
    // cycles 2..: ACCESS
    for (int i = 0; i < n_access; i++) begin
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : 32'hDEAD_BEEF;
      pslverr = (i == waits) ? serr : 1'b0;
      check({tag, ".acc_sel_en"}, 64'({psel, penable}), 64'b11);
      check({tag, ".acc_addr"},   64'(paddr),  64'(addr));
      check({tag, ".acc_wdata"},  64'(pwdata), 64'(wdata));
      check({tag, ".acc_write"},  64'(pwrite), 64'(we));
      check({tag, ".acc_rspv"},   64'(rsp_valid), 64'd0);
      tick();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    // response cycle
    check({tag, ".rsp_valid"},  64'(rsp_valid), 64'd1);
    check({tag, ".rsp_err"},    64'(rsp_err),   64'(exp_err));
    check({tag, ".rsp_rdata"},  64'(rsp_rdata), 64'(exp_rdata));
    check({tag, ".rsp_sel_en"}, 64'({psel, penable}), 64'b00);
    check({tag, ".rsp_addr"},   64'(paddr), 64'(addr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
    check({tag, ".idle_rspv"},  64'(rsp_valid), 64'd0);
  endtask

  // Out-of-window request: no APB activity, error response on the next cycle.
  task automatic run_decode_err(input string tag, input logic [31:0] addr,
                                input logic [31:0] last_paddr);
    req_valid = 1'b1; req_addr = addr; req_we = 1'b0; req_wdata = 32'h0;
    check({tag, ".c0_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, ".rsp_err"},   64'(rsp_err),   64'd1);
    check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, ".psel"},      64'({psel, penable}), 64'b00);
    check({tag, ".paddr"},     64'(paddr), 64'(last_paddr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".psel2"},      64'(psel),      64'd0);
    check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
    rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst.ready",   64'(req_ready), 64'd1);
    check("rst.rspv",    64'(rsp_valid), 64'd0);
    check("rst.err",     64'(rsp_err),   64'd0);
    check("rst.rdata",   64'(rsp_rdata), 64'd0);
    check("rst.sel_en",  64'({psel, penable}), 64'b00);
    check("rst.paddr",   64'(paddr),  64'd0);
    check("rst.pwdata",  64'(pwdata), 64'd0);
    check("rst.pwrite",  64'(pwrite), 64'd0);

    // Zero-wait write; read data on the bus must not leak into the response
    run_xfer("wr0", 32'h1A10_1004, 1'b1, 32'hCAFE_F00D, 0, 1, 32'hFFFF_FFFF, 1'b0,
             32'h0, 1'b0);
    // Read with 3 wait states: response at cycle 6 (also the timeout boundary)
    run_xfer("rd3", 32'h1A10_3000, 1'b0, 32'h0, 3, 4, 32'h1234_5678, 1'b0,
             32'h1234_5678, 1'b0);
    // Read with slave error: data forced to zero
    run_xfer("rdErr", 32'h1A10_3004, 1'b0, 32'h0, 1, 2, 32'h55AA_55AA, 1'b1,
             32'h0, 1'b1);
    // Dead slave: exactly 4 ACCESS cycles then timeout error
    run_xfer("tmo", 32'h1A10_0000, 1'b0, 32'h0, 100, 4, 32'h0, 1'b0,
             32'h0, 1'b1);
    // Ready on the 4th ACCESS cycle wins over the timeout
    run_xfer("tmoEdge", 32'h1A11_7FFF, 1'b0, 32'h0, 3, 4, 32'hAABB_CCDD, 1'b0,
             32'hAABB_CCDD, 1'b0);
    // Write with waits at window top
    run_xfer("wrTop", 32'h1A11_7FFC, 1'b1, 32'h0BAD_F00D, 2, 3, 32'h1111_1111, 1'b0,
             32'h0, 1'b0);

    // Out-of-window addresses; paddr keeps the last in-window value
    run_decode_err("dec_hi",   32'h1A12_0000, 32'h1A11_7FFC);
    run_decode_err("dec_zero", 32'h0000_0000, 32'h1A11_7FFC);
    run_decode_err("dec_end1", 32'h1A11_8000, 32'h1A11_7FFC);
    run_decode_err("dec_beg1", 32'h1A0F_FFFF, 32'h1A11_7FFC);

    // Stalled response with a new request waiting
    req_valid = 1'b1; req_addr = 32'h1A10_2000; req_we = 1'b0;
    tick();                                  // SETUP
    req_addr = 32'h1A10_2222;                // pending request, must not be taken
    tick();                                  // ACCESS
    pready = 1'b1; prdata = 32'h0F0F_0F0F;
    tick();                                  // RESP
    pready = 1'b0; prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("hold.ready", 64'(req_ready), 64'd0);
      check("hold.rspv",  64'(rsp_valid), 64'd1);
      check("hold.rdata", 64'(rsp_rdata), 64'h0F0F_0F0F);
      check("hold.err",   64'(rsp_err),   64'd0);
      check("hold.psel",  64'(psel),      64'd0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold.idle", 64'(req_ready), 64'd1);

    // Reset during ACCESS aborts the transfer
    req_valid = 1'b1; req_addr = 32'h1A10_4000; req_we = 1'b1; req_wdata = 32'h7777_7777;
    tick();                                  // SETUP
    req_valid = 1'b0;
    tick();                                  // ACCESS, slave stalls
    check("abort.acc", 64'({psel, penable}), 64'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.sel_en", 64'({psel, penable}), 64'b00);
    check("abort.ready",  64'(req_ready), 64'd1);
    check("abort.rspv",   64'(rsp_valid), 64'd0);
    tick();
    check("abort.still_idle", 64'(psel), 64'd0);

    // Recovery after the abort
    run_xfer("post", 32'h1A10_5008, 1'b1, 32'h1357_9BDF, 0, 1, 32'h0, 1'b0,
             32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
